redmule_tile_sequencer: RTL

- Sequences the RedMulE engine over a GEMM job: iterates the M/N/K tile space and issues one tile descriptor per valid/ready handshake to the scheduler/streamer address generators.
- Sits between the controller (which provides latched tile counts and a start pulse) and the scheduler.
- Loop order: K innermost (accumulation), then N, then M outermost.

---
 rtl/redmule_tile_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/redmule_tile_sequencer.sv
// Walks the M/N/K tile space (K innermost, M outermost), one descriptor per valid/ready handshake;
// first tile is valid 1 cycle after start, and the descriptor holds while ready is low. Stall counter via REDMULE_TILE_SEQ_PERF_EN.
module redmule_tile_sequencer #(
  parameter int unsigned DimWidth  = 16,
  parameter int unsigned PerfWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [DimWidth-1:0]  m_tiles_i,
  input  logic [DimWidth-1:0]  n_tiles_i,
  input  logic [DimWidth-1:0]  k_tiles_i,
  output logic                 tile_valid_o,
  input  logic                 tile_ready_i,
  output logic [DimWidth-1:0]  m_idx_o,
  output logic [DimWidth-1:0]  n_idx_o,
  output logic [DimWidth-1:0]  k_idx_o,
  output logic                 first_k_o,
  output logic                 last_k_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [PerfWidth-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e              state;
  logic [DimWidth-1:0] m_max, n_max, k_max;
  logic [DimWidth-1:0] m_nxt, n_nxt, k_nxt;
  logic                hs, k_wrap, n_wrap, dims_ok;

  // Limits are stored as count-1, so a count of 2^DimWidth-1 never needs an extra bit.
  always_comb begin
    hs      = tile_valid_o && tile_ready_i;
    k_wrap  = (k_idx_o == k_max);
    n_wrap  = (n_idx_o == n_max);
    k_nxt   = k_wrap ? '0 : k_idx_o + DimWidth'(1);
    n_nxt   = k_wrap ? (n_wrap ? '0 : n_idx_o + DimWidth'(1)) : n_idx_o;
    m_nxt   = (k_wrap && n_wrap) ? m_idx_o + DimWidth'(1) : m_idx_o;
    dims_ok = (|m_tiles_i) && (|n_tiles_i) && (|k_tiles_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      m_max        <= '0;
      n_max        <= '0;
      k_max        <= '0;
      m_idx_o      <= '0;
      n_idx_o      <= '0;
      k_idx_o      <= '0;
      first_k_o    <= 1'b0;
      last_k_o     <= 1'b0;
      last_o       <= 1'b0;
      tile_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else if (clear_i) begin
      state        <= IDLE;
      m_max        <= '0;
      n_max        <= '0;
      k_max        <= '0;
      m_idx_o      <= '0;
      n_idx_o      <= '0;
      k_idx_o      <= '0;
      first_k_o    <= 1'b0;
      last_k_o     <= 1'b0;
      last_o       <= 1'b0;
      tile_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (dims_ok) begin
              m_max        <= m_tiles_i - DimWidth'(1);
              n_max        <= n_tiles_i - DimWidth'(1);
              k_max        <= k_tiles_i - DimWidth'(1);
              m_idx_o      <= '0;
              n_idx_o      <= '0;
              k_idx_o      <= '0;
              first_k_o    <= 1'b1;
              last_k_o     <= (k_tiles_i == DimWidth'(1));
              last_o       <= (k_tiles_i == DimWidth'(1)) && (n_tiles_i == DimWidth'(1)) &&
                              (m_tiles_i == DimWidth'(1));
              tile_valid_o <= 1'b1;
              busy_o       <= 1'b1;
              state        <= ISSUE;
            end else begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            if (last_o) begin
              tile_valid_o <= 1'b0;
              m_idx_o      <= '0;
              n_idx_o      <= '0;
              k_idx_o      <= '0;
              first_k_o    <= 1'b0;
              last_k_o     <= 1'b0;
              last_o       <= 1'b0;
              done_o       <= 1'b1;
              state        <= DONE;
            end else begin
              m_idx_o   <= m_nxt;
              n_idx_o   <= n_nxt;
              k_idx_o   <= k_nxt;
              first_k_o <= (k_nxt == '0);
              last_k_o  <= (k_nxt == k_max);
              last_o    <= (k_nxt == k_max) && (n_nxt == n_max) && (m_nxt == m_max);
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REDMULE_TILE_SEQ_PERF_EN
  logic start_acc, stall;

  always_comb begin
    start_acc = (state == IDLE) && start_i && dims_ok;
    stall     = (state == ISSUE) && tile_valid_o && !tile_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (clear_i || start_acc) begin
      stall_cnt_o <= '0;
    end else if (stall && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + PerfWidth'(1);
    end
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule
